// File: rtl/fifo_pkg.sv
// Shared types and default widths for the FIFO stream reader slice.
// No logic here; imported by the interface, buffer and top.
package fifo_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_LEN_WIDTH  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;
endpackage

// File: rtl/fifo_stream_reader_if.sv
// Upstream FIFO read port plus downstream valid/ready stream, bundled as one bus.
// master = the reader (drives rd_en and the stream), slave = FIFO + sink side.
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = fifo_pkg::DEF_DATA_WIDTH
) ();
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    modport master (
        output fifo_rd_en, m_valid, m_data,
        input  fifo_empty, fifo_dout, m_ready
    );

    modport slave (
        input  fifo_rd_en, m_valid, m_data,
        output fifo_empty, fifo_dout, m_ready
    );
endinterface

// File: rtl/fifo_reader_skid.sv
// Two-entry in-order output buffer; push lands at the next edge, head is combinational.
// A push into a full buffer without a same-cycle pop is dropped; pop on empty is ignored.
module fifo_reader_skid
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            occupancy,
    output logic [DATA_WIDTH-1:0] head
);
    logic [DATA_WIDTH-1:0] mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            occ_q;
    logic                  do_pop;
    logic                  do_push;

    assign do_pop  = pop && (occ_q != 2'd0);
    assign do_push = push && ((occ_q != 2'd2) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ_q <= occ_q + 2'(do_push) - 2'(do_pop);
        end
    end

    assign occupancy = occ_q;
    assign head      = mem[rd_ptr];
endmodule

// File: rtl/fifo_stream_reader.sv
// Drains burst_len words from a registered-output FIFO into a valid/ready stream.
// rd_en -> m_valid is 2 cycles; rd_en is gated by a 2-slot credit so m_ready stalls never overflow.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] burst_len,
    fifo_stream_reader_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic [LEN_WIDTH-1:0] word_count
);
    rd_state_t             state_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  issued_q;
    logic [LEN_WIDTH-1:0]  count_q;
    logic                  inflight_q;
    logic                  done_q;

    logic [1:0]            occ;
    logic [DATA_WIDTH-1:0] head;
    logic [2:0]            committed;
    logic                  pop;
    logic                  credit_ok;
    logic                  rd_en;
    logic                  last_beat;

    // Buffered words plus the one still on the FIFO's output register.
    assign committed = {1'b0, occ} + {2'b00, inflight_q};
    assign pop       = (occ != 2'd0) && bus.m_ready;
    assign credit_ok = (committed < 3'd2) || ((committed == 3'd2) && pop);
    assign rd_en     = (state_q == RUN) && !bus.fifo_empty && (issued_q < len_q) && credit_ok;
    assign last_beat = pop && (count_q == len_q - LEN_WIDTH'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            issued_q   <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            inflight_q <= rd_en;
            if (pop) begin
                count_q <= count_q + LEN_WIDTH'(1);
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        len_q    <= burst_len;
                        issued_q <= '0;
                        count_q  <= '0;
                        if (burst_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (rd_en) begin
                        issued_q <= issued_q + LEN_WIDTH'(1);
                        if (issued_q + LEN_WIDTH'(1) == len_q) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (last_beat) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    fifo_reader_skid #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (bus.fifo_dout),
        .pop       (pop),
        .occupancy (occ),
        .head      (head)
    );

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = (occ != 2'd0);
    assign bus.m_data     = head;
    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign word_count     = count_q;
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: queue-based FIFO/scoreboard model, directed scenarios, random bursts.
// Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
module tb_fifo_stream_reader;
    localparam int DW = 8;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LW-1:0] burst_len;
    logic          busy;
    logic          done;
    logic [LW-1:0] word_count;

    fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();

    fifo_stream_reader #(
        .DATA_WIDTH(DW),
        .LEN_WIDTH (LW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .burst_len  (burst_len),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Upstream FIFO contents, words read but not yet delivered, and the word on the FIFO output register.
    logic [DW-1:0] fq[$];
    logic [DW-1:0] sb[$];
    logic [DW-1:0] pend;
    bit            pend_vld;

    // Burst-level reference state.
    bit            m_busy;
    bit            exp_done;
    int            m_len, m_beats, m_reads;
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    int            cyc, first_rd_cyc, first_vld_cyc, first_beat_cyc, last_beat_cyc, done_cnt;
    int            ready_mode, feed_left;
    logic [DW-1:0] next_word;

    task automatic model_reset();
        m_busy = 0; exp_done = 0; m_len = 0; m_beats = 0; m_reads = 0;
        sb.delete(); pend_vld = 0; prev_stall = 0;
        first_rd_cyc = -1; first_vld_cyc = -1; first_beat_cyc = -1; last_beat_cyc = -1;
    endtask

    task automatic monitor();
        bit was_busy, beat, rd;
        cyc++;
        if (rst) begin
            chk_eq("rst_outputs", {12'd0, bus.fifo_rd_en, bus.m_valid, busy, done, bus.m_data, word_count}, 32'd0);
            model_reset();
            return;
        end
        chk_eq("busy", busy, m_busy);
        chk_eq("done", done, exp_done);
        chk_eq("word_count", word_count, m_len > 0 || m_beats > 0 ? m_beats : 0);
        if (done) done_cnt++;
        if (prev_stall) begin
            chk_eq("stall_valid", bus.m_valid, 1);
            chk_eq("stall_data", bus.m_data, prev_data);
        end
        rd = bus.fifo_rd_en;
        if (rd) begin
            chk_eq("rd_en_legal", (!bus.fifo_empty && m_busy && (m_reads < m_len)), 1);
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
        end
        if (bus.m_valid && first_vld_cyc < 0) begin
            first_vld_cyc = cyc;
            chk_eq("first_latency", cyc - first_rd_cyc, 2);
        end
        beat = bus.m_valid && bus.m_ready;
        if (beat) begin
            chk_eq("beat_in_burst", (sb.size() != 0 && m_beats < m_len), 1);
            if (sb.size() != 0) chk_eq("m_data", bus.m_data, sb.pop_front());
            if (first_beat_cyc < 0) first_beat_cyc = cyc;
            last_beat_cyc = cyc;
        end
        prev_stall = bus.m_valid && !bus.m_ready;
        prev_data  = bus.m_data;

        // Advance the model across the coming rising edge.
        was_busy = m_busy;
        exp_done = 0;
        if (beat) begin
            m_beats++;
            if (m_beats == m_len) begin
                m_busy   = 0;
                exp_done = 1;
            end
        end
        if (rd && !bus.fifo_empty && fq.size() != 0) begin
            m_reads++;
            pend     = fq.pop_front();
            pend_vld = 1;
            sb.push_back(pend);
        end
        if (start && !was_busy) begin
            m_len = int'(burst_len); m_beats = 0; m_reads = 0;
            first_rd_cyc = -1; first_vld_cyc = -1; first_beat_cyc = -1; last_beat_cyc = -1;
            if (burst_len == '0) exp_done = 1;
            else m_busy = 1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        bus.fifo_dout = pend_vld ? pend : '0;
        pend_vld = 0;
        if (feed_left > 0 && $urandom_range(0, 1) == 1) begin
            fq.push_back(next_word);
            next_word++;
            feed_left--;
        end
        bus.fifo_empty = (fq.size() == 0);
        case (ready_mode)
            0:       bus.m_ready = 1'b1;
            1:       bus.m_ready = !bus.m_ready;
            default: bus.m_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            fq.push_back(next_word);
            next_word++;
        end
    endtask

    task automatic do_start(input int len);
        burst_len = LW'(len);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done_cnt != d0) break;
        end
        chk_eq(tag, done_cnt - d0, 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; burst_len = '0;
        bus.fifo_empty = 1'b1; bus.fifo_dout = '0; bus.m_ready = 1'b0;
        ready_mode = 0; feed_left = 0; next_word = 8'h40; cyc = 0; done_cnt = 0;
        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();

        // Preloaded 0x11..0x14, always ready: back-to-back beats.
        fq.push_back(8'h11); fq.push_back(8'h12); fq.push_back(8'h13); fq.push_back(8'h14);
        ready_mode = 0;
        do_start(4);
        wait_done("t1_done", 20);
        chk_eq("t1_word_count", word_count, 4);
        chk_eq("t1_back_to_back", last_beat_cyc - first_beat_cyc, 3);
        repeat (2) tick();

        // Ready toggling every cycle.
        ready_mode = 1;
        push_words(6);
        do_start(6);
        wait_done("t2_done", 60);
        chk_eq("t2_word_count", word_count, 6);
        repeat (2) tick();

        // FIFO runs dry mid-burst and refills later.
        ready_mode = 0;
        push_words(2);
        do_start(5);
        repeat (10) tick();
        push_words(3);
        wait_done("t3_done", 60);
        chk_eq("t3_word_count", word_count, 5);
        repeat (2) tick();

        // Zero-length burst.
        do_start(0);
        wait_done("t4_done", 4);
        chk_eq("t4_word_count", word_count, 0);
        repeat (2) tick();

        // Reset in the middle of an 8-word burst, then a clean 3-word burst.
        push_words(10);
        do_start(8);
        for (int i = 0; i < 40 && m_beats < 2; i++) tick();
        chk_eq("t5_midburst_count", word_count, 2);
        #1 rst = 1'b1;
        #1 chk_eq("t5_async_rst", {12'd0, bus.fifo_rd_en, bus.m_valid, busy, done, bus.m_data, word_count}, 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        fq.delete();
        bus.fifo_empty = 1'b1;
        tick();
        push_words(3);
        do_start(3);
        wait_done("t5_done", 30);
        chk_eq("t5_word_count", word_count, 3);
        repeat (2) tick();

        // Second start while busy must be ignored.
        ready_mode = 2;
        push_words(4);
        do_start(4);
        tick();
        do_start(9);
        wait_done("t6_done", 60);
        chk_eq("t6_word_count", word_count, 4);
        repeat (6) tick();

        // Random bursts, random ready, words trickling into the FIFO.
        for (int b = 0; b < 20; b++) begin
            int len;
            len = $urandom_range(0, 10);
            ready_mode = 2;
            feed_left = len;
            do_start(len);
            wait_done("rnd_done", 400);
            chk_eq("rnd_word_count", word_count, len);
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
